pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, branch, jump, call and return next-PC
// selection with a circular return-address stack and sticky overflow/underflow flag.
module pc_sequencer #(
  parameter int unsigned      XLEN         = 64,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      IMM_SHIFT    = 0,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      mode,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] MODE_BRANCH = 3'b001;
  localparam logic [2:0] MODE_JUMP   = 3'b010;
  localparam logic [2:0] MODE_CALL   = 3'b011;
  localparam logic [2:0] MODE_RET    = 3'b100;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   sp_q, sp_d;
  logic            err_q, err_d;
  logic            push;
  logic            advance;
  logic            full;
  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   sp_top;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  assign advance = valid_q & ~stall;
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign seq_pc  = pc_q + XLEN'(STEP);
  assign sp_top  = sp_q - PW'(1);

  // sp_q names the next free slot; once full it also names the oldest entry,
  // so a push on a full stack overwrites the oldest without extra bookkeeping.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (advance) begin
      case (mode)
        MODE_BRANCH: pc_d = pc_q + (imm << IMM_SHIFT);
        MODE_JUMP:   pc_d = target;
        MODE_CALL: begin
          push = 1'b1;
          pc_d = target;
          sp_d = sp_q + PW'(1);
          if (full) err_d = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
        MODE_RET: begin
          if (cnt_q != '0) begin
            pc_d  = ras_q[sp_top];
            sp_d  = sp_top;
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = target;
            err_d = 1'b1;
          end
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) ras_q[sp_q] <= seq_pc;
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = full;
  assign ras_err   = err_q;

endmodule
